// File: rtl/elevator_pkg.sv
// elevator_pkg: motor command, door state and fault bit encodings shared by the
// shaft model and its controller.
package elevator_pkg;
   typedef enum logic [1:0] {
      AC_STOP  = 2'b00,
      AC_UP    = 2'b01,
      AC_DOWN  = 2'b10,
      AC_BRAKE = 2'b11
   } ac_e;
   localparam logic [1:0] DOOR_CLOSED_S  = 2'd0;
   localparam logic [1:0] DOOR_OPENING_S = 2'd1;
   localparam logic [1:0] DOOR_OPEN_S    = 2'd2;
   localparam logic [1:0] DOOR_CLOSING_S = 2'd3;
   localparam int FAULT_INTERLOCK = 0;
   localparam int FAULT_LIMIT     = 1;
   function automatic logic [3:0] floor_sensors(input logic [4:0] pos, input int tc);
      for (int k = 0; k < 4; k++) floor_sensors[k] = (int'(pos) == k * tc);
   endfunction
endpackage

// File: rtl/elevator_door.sv
// elevator_door: door stroke FSM; the counter is the door position, 0 = shut,
// DOOR_CYCLES = fully open, so a reversal simply changes counting direction.
module elevator_door
   import elevator_pkg::*;
#(
   parameter int DOOR_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic open_i,
   input  logic at_floor_i,
   input  logic motor_idle_i,
   output logic door_closed_o,
   output logic door_open_o,
   output logic interlock_o
);
   localparam int CW = $clog2(DOOR_CYCLES + 1);
   localparam logic [CW-1:0] FULL = CW'(DOOR_CYCLES);
   logic [1:0] state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      interlock_o = 1'b0;
      if (state_q == DOOR_CLOSED_S) begin
         if (open_i && at_floor_i && motor_idle_i) begin
            cnt_d = CW'(1);
            state_d = (FULL == CW'(1)) ? DOOR_OPEN_S : DOOR_OPENING_S;
         end else begin
            interlock_o = open_i;
         end
      end else if (open_i) begin
         cnt_d = (cnt_q == FULL) ? FULL : cnt_q + CW'(1);
         state_d = (cnt_d == FULL) ? DOOR_OPEN_S : DOOR_OPENING_S;
      end else begin
         cnt_d = cnt_q - CW'(1);
         state_d = (cnt_d == '0) ? DOOR_CLOSED_S : DOOR_CLOSING_S;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= DOOR_CLOSED_S;
         cnt_q <= '0;
         door_closed_o <= 1'b1;
         door_open_o <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         door_closed_o <= (state_d == DOOR_CLOSED_S);
         door_open_o <= (state_d == DOOR_OPEN_S);
      end
   end
endmodule

// File: rtl/elevator_shaft.sv
// elevator_shaft: four-floor car/shaft model with fine position counter, floor
// sensors, door sub-FSM and sticky interlock/limit fault flags.
module elevator_shaft
   import elevator_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 10,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] AC,
   input  logic       Open,
   output logic       S1,
   output logic       S2,
   output logic       S3,
   output logic       S4,
   output logic       DOOR_CLOSED,
   output logic       DOOR_OPEN,
   output logic [4:0] POS,
   output logic [1:0] FAULT
);
   localparam logic [4:0] TOP = 5'(3 * TRAVEL_CYCLES);
   logic [4:0] pos_q, pos_d;
   logic [3:0] s_q;
   logic [1:0] fault_q, fault_d;
   logic move_req, move_ok, door_int;
   assign move_req = (AC == AC_UP) || (AC == AC_DOWN);
   assign move_ok = move_req && DOOR_CLOSED && !Open;
   elevator_door #(.DOOR_CYCLES(DOOR_CYCLES)) u_door (
      .clk_i        (CLK),
      .rst_i        (RESET),
      .open_i       (Open),
      .at_floor_i   (|s_q),
      .motor_idle_i (!move_req),
      .door_closed_o(DOOR_CLOSED),
      .door_open_o  (DOOR_OPEN),
      .interlock_o  (door_int)
   );
   always_comb begin
      pos_d = pos_q;
      fault_d = fault_q;
      fault_d[FAULT_INTERLOCK] = fault_q[FAULT_INTERLOCK] | door_int | (move_req && !move_ok);
      if (move_ok) begin
         if ((AC == AC_UP && pos_q == TOP) || (AC == AC_DOWN && pos_q == '0))
            fault_d[FAULT_LIMIT] = 1'b1;
         else
            pos_d = (AC == AC_UP) ? pos_q + 5'd1 : pos_q - 5'd1;
      end
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pos_q <= '0;
         s_q <= 4'b0001;
         fault_q <= '0;
      end else begin
         pos_q <= pos_d;
         s_q <= floor_sensors(pos_d, TRAVEL_CYCLES);
         fault_q <= fault_d;
      end
   end
   assign POS = pos_q;
   assign {S4, S3, S2, S1} = s_q;
   assign FAULT = fault_q;
endmodule
